// File: rtl/am_codec_core.sv
// am_codec_core: offset-binary AM modulator (1+k*x)*c with full-wave rectifier and boxcar
// envelope detector. Define DC_BLOCK_EN to add first-order DC removal on the envelope output.
module am_codec_core #(
    parameter int DW_BB    = 12,
    parameter int DW_CAR   = 8,
    parameter int DW_DAC   = 14,
    parameter int AVG_LOG2 = 4,
    parameter int GAIN_W   = 4
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              in_valid,
    input  logic              mode,
    input  logic [DW_BB-1:0]  bb_in,
    input  logic [DW_CAR-1:0] car_in,
    input  logic [DW_CAR-1:0] am_in,
    input  logic [GAIN_W-1:0] gain,
    input  logic              clr_sat,
    output logic [DW_DAC-1:0] mod_out,
    output logic              mod_valid,
    output logic [DW_DAC-1:0] env_out,
    output logic              env_valid,
    output logic              sat
);
    localparam int PW    = DW_BB + DW_CAR;
    localparam int RW    = PW - 1;
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = RW + AVG_LOG2;
    localparam int MW    = DW_BB + GAIN_W;
    localparam int AW    = MW + 1;

    localparam logic signed [AW-1:0]  A_MID     = AW'(1 << (DW_BB - 1));
    localparam logic signed [AW-1:0]  A_MAX     = AW'((1 << DW_BB) - 1);
    localparam logic [AVG_LOG2:0]     FILL_FULL = (AVG_LOG2 + 1)'(DEPTH);
    localparam logic [AVG_LOG2:0]     FILL_ONE  = (AVG_LOG2 + 1)'(1);
    localparam logic [AVG_LOG2-1:0]   PTR_ONE   = AVG_LOG2'(1);

    // Stage 1: input capture, offset binary -> two's complement
    logic                     v1, flush1, mode1, mode_last;
    logic signed [DW_BB-1:0]  bb_s1;
    logic signed [DW_CAR-1:0] car_s1, am_s1;
    logic [GAIN_W-1:0]        gain1;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            v1        <= 1'b0;
            flush1    <= 1'b0;
            mode1     <= 1'b0;
            mode_last <= 1'b0;
            bb_s1     <= '0;
            car_s1    <= '0;
            am_s1     <= '0;
            gain1     <= '0;
        end else begin
            v1     <= in_valid;
            flush1 <= in_valid && (mode != mode_last);
            mode1  <= mode;
            if (in_valid) mode_last <= mode;
            bb_s1  <= {~bb_in[DW_BB-1], bb_in[DW_BB-2:0]};
            car_s1 <= {~car_in[DW_CAR-1], car_in[DW_CAR-2:0]};
            am_s1  <= {~am_in[DW_CAR-1], am_in[DW_CAR-2:0]};
            gain1  <= gain;
        end
    end

    // Stage 2: scaled baseband plus midscale offset, clamped to unsigned range
    logic signed [MW-1:0]     scaled;
    logic signed [AW-1:0]     a_full;
    logic [DW_BB-1:0]         a_clamp;
    logic                     clamp2;

    always_comb begin
        scaled = MW'(bb_s1) * MW'($signed({1'b0, gain1}));
        a_full = AW'(scaled >>> (GAIN_W - 1)) + A_MID;
        if (a_full[AW-1]) begin
            a_clamp = '0;
            clamp2  = 1'b1;
        end else if (a_full > A_MAX) begin
            a_clamp = '1;
            clamp2  = 1'b1;
        end else begin
            a_clamp = a_full[DW_BB-1:0];
            clamp2  = 1'b0;
        end
    end

    logic                     v2, flush2, mode2;
    logic [DW_BB-1:0]         a2;
    logic signed [DW_CAR-1:0] car_s2, am_s2;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            v2     <= 1'b0;
            flush2 <= 1'b0;
            mode2  <= 1'b0;
            a2     <= '0;
            car_s2 <= '0;
            am_s2  <= '0;
            sat    <= 1'b0;
        end else begin
            v2     <= v1;
            flush2 <= flush1;
            mode2  <= mode1;
            a2     <= a_clamp;
            car_s2 <= car_s1;
            am_s2  <= am_s1;
            if (v1 && clamp2) sat <= 1'b1;
            else if (clr_sat) sat <= 1'b0;
        end
    end

    // Stage 3: product; magnitude bound of a*car_s keeps it inside PW signed bits
    logic signed [PW-1:0]     p_nxt, p3;
    logic                     v3, flush3, mode3;
    logic signed [DW_CAR-1:0] am_s3;

    always_comb begin
        p_nxt = PW'($signed({1'b0, a2})) * PW'(car_s2);
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            p3        <= '0;
            mod_out   <= '0;
            mod_valid <= 1'b0;
            v3        <= 1'b0;
            flush3    <= 1'b0;
            mode3     <= 1'b0;
            am_s3     <= '0;
        end else begin
            p3        <= p_nxt;
            mod_out   <= {~p_nxt[PW-1], p_nxt[PW-2 -: DW_DAC-1]};
            mod_valid <= v2;
            v3        <= v2;
            flush3    <= flush2;
            mode3     <= mode2;
            am_s3     <= am_s2;
        end
    end

    // Stage 4: source select and full-wave rectify
    logic signed [PW-1:0]     src;
    logic [RW-1:0]            r_nxt, r4;
    logic                     v4, flush4;

    always_comb begin
        src = mode3 ? {am_s3, {DW_BB{1'b0}}} : p3;
        if (src[PW-1] && (src[PW-2:0] == '0)) r_nxt = '1;
        else if (src[PW-1])                   r_nxt = RW'(-src);
        else                                  r_nxt = src[RW-1:0];
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r4     <= '0;
            v4     <= 1'b0;
            flush4 <= 1'b0;
        end else begin
            r4     <= r_nxt;
            v4     <= v3;
            flush4 <= flush3;
        end
    end

    // Stage 5: running boxcar sum; a flush restarts accumulation with the current sample
    logic [RW-1:0]            ring [DEPTH];
    logic [AVG_LOG2-1:0]      ptr, ptr_nxt, wr_idx;
    logic [AVG_LOG2:0]        fill, fill_nxt;
    logic [SW-1:0]            sum, sum_nxt;

    always_comb begin
        sum_nxt  = sum;
        ptr_nxt  = ptr;
        fill_nxt = fill;
        wr_idx   = ptr;
        if (v4) begin
            if (flush4) begin
                wr_idx   = '0;
                sum_nxt  = SW'(r4);
                ptr_nxt  = PTR_ONE;
                fill_nxt = FILL_ONE;
            end else begin
                sum_nxt  = sum + SW'(r4) - ((fill == FILL_FULL) ? SW'(ring[ptr]) : '0);
                ptr_nxt  = ptr + PTR_ONE;
                fill_nxt = (fill == FILL_FULL) ? fill : fill + FILL_ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (v4) ring[wr_idx] <= r4;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sum  <= '0;
            ptr  <= '0;
            fill <= '0;
        end else begin
            sum  <= sum_nxt;
            ptr  <= ptr_nxt;
            fill <= fill_nxt;
        end
    end

    // Envelope is registered from sum_nxt so the average shares the stage-5 edge
    logic [DW_DAC-1:0]        env_top, env_fmt;

    always_comb begin
        env_top = {1'b0, sum_nxt[SW-1 -: DW_DAC-1]};
    end

`ifdef DC_BLOCK_EN
    localparam int FRAC = 10;
    localparam int DCW  = DW_DAC + 1 + FRAC;

    logic signed [DCW-1:0]    dc, dc_nxt, dc_err, env_fx;
    logic signed [DW_DAC+1:0] diff;
    logic [DW_DAC-1:0]        dv;

    always_comb begin
        env_fx = $signed({1'b0, env_top, {FRAC{1'b0}}});
        dc_err = env_fx - dc;
        dc_nxt = v4 ? dc + (dc_err >>> FRAC) : dc;
        diff   = $signed({2'b00, env_top}) - $signed({dc[DCW-1], dc[DCW-1:FRAC]});
        if ((diff[DW_DAC+1:DW_DAC-1] == 3'b000) || (diff[DW_DAC+1:DW_DAC-1] == 3'b111))
            dv = diff[DW_DAC-1:0];
        else if (diff[DW_DAC+1])
            dv = {1'b1, {(DW_DAC-1){1'b0}}};
        else
            dv = {1'b0, {(DW_DAC-1){1'b1}}};
        env_fmt = {~dv[DW_DAC-1], dv[DW_DAC-2:0]};
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) dc <= '0;
        else        dc <= dc_nxt;
    end
`else
    always_comb begin
        env_fmt = env_top;
    end
`endif

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            env_out   <= '0;
            env_valid <= 1'b0;
        end else begin
            env_out   <= env_fmt;
            env_valid <= v4 && (fill_nxt == FILL_FULL);
        end
    end

endmodule

// File: tb/tb_am_codec_core.sv
// tb_am_codec_core: directed scoreboard bench for am_codec_core (default build, no DC block).
module tb_am_codec_core;
    localparam int DW_BB    = 12;
    localparam int DW_CAR   = 8;
    localparam int DW_DAC   = 14;
    localparam int AVG_LOG2 = 4;
    localparam int GAIN_W   = 4;
    localparam int PW       = DW_BB + DW_CAR;
    localparam int DEPTH    = 1 << AVG_LOG2;
    localparam int NEG_MAX  = -(1 << (PW - 1));

    logic              CLK = 1'b0;
    logic              RST_n;
    logic              in_valid, mode, clr_sat;
    logic [DW_BB-1:0]  bb_in;
    logic [DW_CAR-1:0] car_in, am_in;
    logic [GAIN_W-1:0] gain;
    logic [DW_DAC-1:0] mod_out, env_out;
    logic              mod_valid, env_valid, sat;

    always #5 CLK = ~CLK;

    am_codec_core #(
        .DW_BB(DW_BB), .DW_CAR(DW_CAR), .DW_DAC(DW_DAC), .AVG_LOG2(AVG_LOG2), .GAIN_W(GAIN_W)
    ) dut (
        .CLK(CLK), .RST_n(RST_n), .in_valid(in_valid), .mode(mode),
        .bb_in(bb_in), .car_in(car_in), .am_in(am_in), .gain(gain), .clr_sat(clr_sat),
        .mod_out(mod_out), .mod_valid(mod_valid), .env_out(env_out),
        .env_valid(env_valid), .sat(sat)
    );

    typedef struct {
        int                due;
        logic [DW_DAC-1:0] val;
    } exp_t;

    exp_t mod_q[$];
    exp_t env_q[$];
    int   box[$];
    bit   m_last;
    int   cyc, total, bad;

    function automatic int p_model(input int bb, input int car, input int g);
        int a;
        a = (1 << (DW_BB - 1)) + (((bb - (1 << (DW_BB - 1))) * g) >>> (GAIN_W - 1));
        if (a < 0) a = 0;
        else if (a > (1 << DW_BB) - 1) a = (1 << DW_BB) - 1;
        return a * (car - (1 << (DW_CAR - 1)));
    endfunction

    function automatic logic [DW_DAC-1:0] mod_model(input int p);
        int t;
        t = ((p >>> (PW - DW_DAC)) & ((1 << DW_DAC) - 1)) ^ (1 << (DW_DAC - 1));
        return t[DW_DAC-1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit   ev;
        exp_t e;
        @(posedge CLK);
        cyc++;
        #1;
        ev = (mod_q.size() > 0) && (mod_q[0].due == cyc);
        total++;
        assert (mod_valid === ev) else begin
            bad++;
            $error("FAIL mod_valid cyc=%0d: observed=%b expected=%b", cyc, mod_valid, ev);
        end
        if (ev) begin
            e = mod_q.pop_front();
            total++;
            assert (mod_out === e.val) else begin
                bad++;
                $error("FAIL mod_out cyc=%0d: observed=%h expected=%h", cyc, mod_out, e.val);
            end
        end
        ev = (env_q.size() > 0) && (env_q[0].due == cyc);
        total++;
        assert (env_valid === ev) else begin
            bad++;
            $error("FAIL env_valid cyc=%0d: observed=%b expected=%b", cyc, env_valid, ev);
        end
        if (ev) begin
            e = env_q.pop_front();
            total++;
            assert (env_out === e.val) else begin
                bad++;
                $error("FAIL env_out cyc=%0d: observed=%h expected=%h", cyc, env_out, e.val);
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Drive one sample and push the expected mod/env results with their due cycles
    task automatic send(input int bb, input int car, input int am, input bit md, input int g);
        int   p, src, r, sum, t;
        exp_t e;
        bb_in    = bb[DW_BB-1:0];
        car_in   = car[DW_CAR-1:0];
        am_in    = am[DW_CAR-1:0];
        gain     = g[GAIN_W-1:0];
        mode     = md;
        in_valid = 1'b1;
        p = p_model(bb, car, g);
        e.due = cyc + 3;
        e.val = mod_model(p);
        mod_q.push_back(e);
        src = md ? (am - (1 << (DW_CAR - 1))) * (1 << DW_BB) : p;
        if (src == NEG_MAX) r = -NEG_MAX - 1;
        else                r = (src < 0) ? -src : src;
        if (md != m_last) box.delete();
        m_last = md;
        box.push_back(r);
        if (box.size() > DEPTH) void'(box.pop_front());
        if (box.size() == DEPTH) begin
            sum = 0;
            foreach (box[i]) sum += box[i];
            t = (sum >>> AVG_LOG2) >>> (PW - DW_DAC);
            e.due = cyc + 5;
            e.val = t[DW_DAC-1:0];
            env_q.push_back(e);
        end
        tick();
    endtask

    task automatic send_rand(input bit md, input int am);
        send(int'($urandom_range(0, 4095)), int'($urandom_range(0, 255)), am, md,
             int'($urandom_range(0, 15)));
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; m_last = 1'b0;
        RST_n = 1'b0; in_valid = 1'b0; mode = 1'b0; clr_sat = 1'b0;
        bb_in = '0; car_in = '0; am_in = '0; gain = '0;

        // Reset state
        repeat (3) tick();
        check("reset mod_out", 32'(mod_out), 32'h0);
        check("reset env_out", 32'(env_out), 32'h0);
        check("reset sat", 32'(sat), 32'h0);
        RST_n = 1'b1;
        idle(2);

        // Midscale baseband, max carrier
        send('h800, 'hFF, 'h80, 1'b0, 8);
        idle(2);
        check("t2 mod_valid", 32'(mod_valid), 32'h1);
        check("t2 mod_out", 32'(mod_out), 32'h2FE0);
        check("t2 sat", 32'(sat), 32'h0);

        // Low clamp, sticky sat, clear
        send('h000, 'hFF, 'h80, 1'b0, 15);
        idle(2);
        check("t3 mod_out", 32'(mod_out), 32'h2000);
        check("t3 sat set", 32'(sat), 32'h1);
        idle(6);
        check("t3 sat held", 32'(sat), 32'h1);
        clr_sat = 1'b1; tick(); clr_sat = 1'b0;
        check("t3 sat cleared", 32'(sat), 32'h0);

        // High clamp
        send('hFFF, 'h00, 'h80, 1'b0, 15);
        idle(3);
        check("high clamp sat", 32'(sat), 32'h1);
        clr_sat = 1'b1; tick(); clr_sat = 1'b0;

        // Set wins over clear on the same edge
        send('h000, 'h10, 'h80, 1'b0, 15);
        in_valid = 1'b0; clr_sat = 1'b1; tick(); clr_sat = 1'b0;
        check("sat priority", 32'(sat), 32'h1);
        clr_sat = 1'b1; tick(); clr_sat = 1'b0;
        check("sat clear2", 32'(sat), 32'h0);

        // Zero gain: pure carrier, never saturates
        send('h000, 'h00, 'h80, 1'b0, 0);
        send('hFFF, 'hFF, 'h80, 1'b0, 0);
        idle(4);
        check("gain0 sat", 32'(sat), 32'h0);

        // External AM at most-negative code
        for (int i = 0; i < 20; i++) send_rand(1'b1, 'h00);
        idle(6);
        check("t4 env_out", 32'(env_out), 32'h1FFF);
        check("t4 env_valid idle", 32'(env_valid), 32'h0);

        // Mode toggles mid-stream
        for (int i = 0; i < 4; i++) send_rand(1'b1, 'h00);
        for (int i = 0; i < 6; i++) send_rand(1'b0, 0);
        for (int i = 0; i < 18; i++) send_rand(1'b1, 'h00);
        // Mode change while idle must not flush
        in_valid = 1'b0; mode = 1'b0; tick(); tick();
        send_rand(1'b1, 'hFF);
        send_rand(1'b1, 'h7F);
        send_rand(1'b1, 'h80);
        idle(6);

        // Loopback envelope with gaps
        for (int i = 0; i < 24; i++) begin
            send_rand(1'b0, 0);
            if (i % 5 == 4) idle(1);
        end
        idle(6);

        // Asynchronous reset mid-stream
        send('h000, 'h40, 'h80, 1'b0, 15);
        send_rand(1'b0, 0);
        send_rand(1'b0, 0);
        check("pre-reset mod_valid", 32'(mod_valid), 32'h1);
        check("pre-reset sat", 32'(sat), 32'h1);
        in_valid = 1'b0;
        RST_n = 1'b0;
        #2;
        check("async rst mod_out", 32'(mod_out), 32'h0);
        check("async rst mod_valid", 32'(mod_valid), 32'h0);
        check("async rst env_out", 32'(env_out), 32'h0);
        check("async rst env_valid", 32'(env_valid), 32'h0);
        check("async rst sat", 32'(sat), 32'h0);
        mod_q.delete(); env_q.delete(); box.delete(); m_last = 1'b0;
        tick(); tick();
        RST_n = 1'b1;
        for (int i = 0; i < 18; i++) send_rand(1'b1, int'($urandom_range(0, 255)));
        idle(8);

        total++;
        assert ((mod_q.size() == 0) && (env_q.size() == 0)) else begin
            bad++;
            $error("FAIL drain: observed mod_q=%0d env_q=%0d expected 0", mod_q.size(), env_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
